// File: rtl/sdram_port_arbiter_v2_pkg.sv
// rtl/sdram_port_arbiter_v2_pkg.sv - shared arbitration policy encodings and grant helper functions
package sdram_arb_pkg;

  localparam int POL_RR   = 0;
  localparam int POL_PRIO = 1;
  localparam int MAXP     = 16;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [3:0] onehot2bin(input logic [MAXP-1:0] oh);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < MAXP; i++) begin
      if (oh[i]) res = res | 4'(i);
    end
    return res;
  endfunction

  function automatic logic [MAXP-1:0] prio_next(input logic [MAXP-1:0] req);
    logic [MAXP-1:0] res;
    res = '0;
    for (int i = MAXP-1; i >= 0; i--) begin
      if (req[i]) res = 16'(1) << i;
    end
    return res;
  endfunction

  // Scan owner+1 upward with wrap; the owner itself is reached last (off == n).
  function automatic logic [MAXP-1:0] rr_next(input logic [MAXP-1:0] cur,
                                               input logic [MAXP-1:0] req,
                                               input int n);
    logic [MAXP-1:0] res;
    logic            found;
    logic [3:0]      ib;
    int              c;
    res   = cur;
    found = 1'b0;
    c     = int'(onehot2bin(cur));
    for (int off = 1; off <= MAXP; off++) begin
      if (n > 0 && off <= n && !found) begin
        ib = 4'((c + off) % n);
        if (req[ib]) begin
          res   = 16'(1) << ib;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_v2_if.sv
// rtl/sdram_port_arbiter_v2_if.sv - arbiter-to-controller command/data bus
interface sdram_port_arbiter_v2_if #(
  parameter int AW = 32,
  parameter int DW = 16
);
  logic [AW-1:0]   adr_o;
  logic            we_o;
  logic            acc_o;
  logic [DW-1:0]   dat_o;
  logic [DW/8-1:0] sel_o;
  logic            dv_o;
  logic            ack_i;
  logic            vld_i;

  modport master (output adr_o, we_o, acc_o, dat_o, sel_o, dv_o, input ack_i, vld_i);
  modport slave  (input adr_o, we_o, acc_o, dat_o, sel_o, dv_o, output ack_i, vld_i);
endinterface

// File: rtl/sdram_port_arbiter_v2_grant.sv
// rtl/sdram_port_arbiter_v2_grant.sv - owner register, quantum counter and policy select
module sdram_arb_grant
  import sdram_arb_pkg::*;
#(
  parameter int WB_PORTS = 3,
  parameter int QUANTUM  = 4,
  parameter int POL_SEL  = POL_RR,
  parameter int PW       = 2,
  parameter int QW       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle_i,
  input  logic [WB_PORTS-1:0] acc_i,
  input  logic                ack_i,
  output logic [WB_PORTS-1:0] grant_o,
  output logic [PW-1:0]       grant_enc_o,
  output logic                quantum_exp_o
);

  localparam logic [QW-1:0] QMAX = QW'(QUANTUM);

  logic [WB_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]       enc_q, enc_d;
  logic [QW-1:0]       cnt_q, cnt_d;
  logic                qexp_q, qexp_d;
  logic [MAXP-1:0]     pick;
  logic                owner_acc, other_req, sw, pick_ok;

  always_comb begin
    owner_acc = |(acc_i & grant_q);
    other_req = |(acc_i & ~grant_q);
    // Never re-arbitrate on an ack cycle so the ack lands on the port it belongs to.
    sw = idle_i & ~ack_i & (~owner_acc | (qexp_q & other_req));
    if (POL_SEL == POL_PRIO) pick = prio_next(16'(acc_i));
    else                     pick = rr_next(16'(grant_q), 16'(acc_i), WB_PORTS);
    pick_ok = ~|(pick >> WB_PORTS);

    grant_d = grant_q;
    if (sw && (|acc_i) && pick_ok) grant_d = pick[WB_PORTS-1:0];
    enc_d = PW'(onehot2bin(16'(grant_d)));

    cnt_d = cnt_q;
    if (grant_d != grant_q)             cnt_d = '0;
    else if (ack_i && (cnt_q != QMAX))  cnt_d = cnt_q + 1'b1;
    qexp_d = (QUANTUM != 0) && (cnt_d == QMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= WB_PORTS'(1);
      enc_q   <= '0;
      cnt_q   <= '0;
      qexp_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      qexp_q  <= qexp_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_enc_o   = enc_q;
  assign quantum_exp_o = qexp_q;

endmodule

// File: rtl/sdram_port_arbiter_v2.sv
// rtl/sdram_port_arbiter_v2.sv - N-port SDRAM command arbiter: owner data mux and ack/vld routing
module sdram_port_arbiter_v2
  import sdram_arb_pkg::*;
#(
  parameter int    WB_PORTS = 3,
  parameter int    DW       = 16,
  parameter int    AW       = 32,
  parameter string POLICY   = "RR",
  parameter int    QUANTUM  = 4,
  parameter int    PW       = clog2_min1(WB_PORTS)
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst,
  input  logic                     sdram_idle_i,
  input  logic [WB_PORTS*AW-1:0]   p_adr_i,
  input  logic [WB_PORTS-1:0]      p_we_i,
  input  logic [WB_PORTS-1:0]      p_acc_i,
  input  logic [WB_PORTS*DW-1:0]   p_dat_i,
  input  logic [WB_PORTS*DW/8-1:0] p_sel_i,
  input  logic [WB_PORTS-1:0]      p_dv_i,
  output logic [WB_PORTS-1:0]      p_ack_o,
  output logic [WB_PORTS-1:0]      p_vld_o,
  sdram_port_arbiter_v2_if.master  ctrl,
  output logic [WB_PORTS-1:0]      grant_o,
  output logic [PW-1:0]            grant_enc_o,
  output logic                     quantum_exp_o
);

  localparam int POL_SEL = (POLICY == "PRIO") ? POL_PRIO : POL_RR;
  localparam int QW      = clog2_min1(QUANTUM + 1);

  sdram_arb_grant #(
    .WB_PORTS (WB_PORTS),
    .QUANTUM  (QUANTUM),
    .POL_SEL  (POL_SEL),
    .PW       (PW),
    .QW       (QW)
  ) u_grant (
    .clk           (sdram_clk),
    .rst           (sdram_rst),
    .idle_i        (sdram_idle_i),
    .acc_i         (p_acc_i),
    .ack_i         (ctrl.ack_i),
    .grant_o       (grant_o),
    .grant_enc_o   (grant_enc_o),
    .quantum_exp_o (quantum_exp_o)
  );

  // Registered index keeps the mux glitch-free; it is always < WB_PORTS.
  always_comb begin
    int idx;
    idx        = int'(grant_enc_o);
    ctrl.adr_o = p_adr_i[idx*AW +: AW];
    ctrl.we_o  = p_we_i[idx];
    ctrl.acc_o = p_acc_i[idx];
    ctrl.dat_o = p_dat_i[idx*DW +: DW];
    ctrl.sel_o = p_sel_i[idx*(DW/8) +: DW/8];
    ctrl.dv_o  = p_dv_i[idx];
  end

  assign p_ack_o = {WB_PORTS{ctrl.ack_i}} & grant_o;
  assign p_vld_o = {WB_PORTS{ctrl.vld_i}} & grant_o;

endmodule

// File: tb/tb_sdram_port_arbiter_v2.sv
// tb/tb_sdram_port_arbiter_v2.sv - directed vector bench for sdram_port_arbiter_v2
module tb_sdram_port_arbiter_v2;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          idle;
  logic [N*AW-1:0]   p_adr;
  logic [N-1:0]      p_we;
  logic [N-1:0]      p_acc;
  logic [N*DW-1:0]   p_dat;
  logic [N*DW/8-1:0] p_sel;
  logic [N-1:0]      p_dv;
  logic          ack;
  logic          vld;

  logic [N-1:0]  rr_p_ack, rr_p_vld, rr_grant;
  logic [1:0]    rr_enc;
  logic          rr_qexp;
  logic [N-1:0]  pr_p_ack, pr_p_vld, pr_grant;
  logic [1:0]    pr_enc;
  logic          pr_qexp;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter_v2_if #(.AW(AW), .DW(DW)) if_rr ();
  sdram_port_arbiter_v2_if #(.AW(AW), .DW(DW)) if_pr ();

  assign if_rr.ack_i = ack;
  assign if_rr.vld_i = vld;
  assign if_pr.ack_i = ack;
  assign if_pr.vld_i = vld;

  sdram_port_arbiter_v2 #(.WB_PORTS(N), .DW(DW), .AW(AW), .POLICY("RR"), .QUANTUM(2)) dut_rr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle),
    .p_adr_i(p_adr), .p_we_i(p_we), .p_acc_i(p_acc), .p_dat_i(p_dat),
    .p_sel_i(p_sel), .p_dv_i(p_dv), .p_ack_o(rr_p_ack), .p_vld_o(rr_p_vld),
    .ctrl(if_rr), .grant_o(rr_grant), .grant_enc_o(rr_enc), .quantum_exp_o(rr_qexp)
  );

  sdram_port_arbiter_v2 #(.WB_PORTS(N), .DW(DW), .AW(AW), .POLICY("PRIO"), .QUANTUM(2)) dut_pr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle),
    .p_adr_i(p_adr), .p_we_i(p_we), .p_acc_i(p_acc), .p_dat_i(p_dat),
    .p_sel_i(p_sel), .p_dv_i(p_dv), .p_ack_o(pr_p_ack), .p_vld_o(pr_p_vld),
    .ctrl(if_pr), .grant_o(pr_grant), .grant_enc_o(pr_enc), .quantum_exp_o(pr_qexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] acc;
    logic       ack;
    logic [2:0] g;
    logic       q;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] acc_v, input logic ack_v, input logic vld_v, input logic rst_v);
    @(posedge clk);
    #1;
    p_acc = acc_v;
    ack   = ack_v;
    vld   = vld_v;
    rst   = rst_v;
    @(negedge clk);
  endtask

  function automatic logic [1:0] enc_of(input logic [2:0] g);
    return (g == 3'b010) ? 2'd1 : (g == 3'b100) ? 2'd2 : 2'd0;
  endfunction

  int vld_seen;

  initial begin
    rst = 1'b1; idle = 1'b1; ack = 1'b0; vld = 1'b0; p_acc = '0;
    p_we = 3'b101; p_dv = 3'b011; p_sel = 6'b11_01_10;
    for (int i = 0; i < N; i++) begin
      p_adr[i*AW +: AW] = 32'hA000_0000 | 32'(i);
      p_dat[i*DW +: DW] = 16'hD000 | 16'(i);
    end

    // RR, quantum 2, all ports requesting, ack every 3rd cycle
    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 3'b001, 1'b0};
    tbl[2]  = '{3'b111, 1'b0, 3'b001, 1'b0};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 3'b001, 1'b1};
    tbl[5]  = '{3'b111, 1'b0, 3'b010, 1'b0};
    tbl[6]  = '{3'b111, 1'b1, 3'b010, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 3'b010, 1'b0};
    tbl[8]  = '{3'b111, 1'b0, 3'b010, 1'b0};
    tbl[9]  = '{3'b111, 1'b1, 3'b010, 1'b0};
    tbl[10] = '{3'b111, 1'b0, 3'b010, 1'b1};
    tbl[11] = '{3'b111, 1'b0, 3'b100, 1'b0};
    tbl[12] = '{3'b111, 1'b1, 3'b100, 1'b0};
    tbl[13] = '{3'b111, 1'b0, 3'b100, 1'b0};
    tbl[14] = '{3'b111, 1'b0, 3'b100, 1'b0};
    tbl[15] = '{3'b111, 1'b1, 3'b100, 1'b0};
    tbl[16] = '{3'b111, 1'b0, 3'b100, 1'b1};
    tbl[17] = '{3'b111, 1'b0, 3'b001, 1'b0};

    repeat (3) step(3'b000, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(3'b000, 1'b0, 1'b0, 1'b0);
      chk("reset_grant", 32'(rr_grant), 32'h1);
      chk("reset_enc", 32'(rr_enc), 32'h0);
      chk("reset_acc_o", 32'(if_rr.acc_o), 32'h0);
      chk("reset_qexp", 32'(rr_qexp), 32'h0);
    end

    for (int r = 0; r < 18; r++) begin
      step(tbl[r].acc, tbl[r].ack, 1'b0, 1'b0);
      chk("rr_grant", 32'(rr_grant), 32'(tbl[r].g));
      chk("rr_enc", 32'(rr_enc), 32'(enc_of(tbl[r].g)));
      chk("rr_qexp", 32'(rr_qexp), 32'(tbl[r].q));
      chk("rr_p_ack", 32'(rr_p_ack), tbl[r].ack ? 32'(tbl[r].g) : 32'h0);
      chk("rr_adr_o", if_rr.adr_o, 32'hA000_0000 | 32'(enc_of(tbl[r].g)));
    end

    // PRIO: port 2 starved by port 1; port 0 wins at the next safe point
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b110, 1'b0, 1'b0, 1'b0); chk("pr_c0_grant", 32'(pr_grant), 32'h1);
    step(3'b110, 1'b1, 1'b0, 1'b0); chk("pr_c1_grant", 32'(pr_grant), 32'h2);
    chk("pr_c1_ack", 32'(pr_p_ack), 32'h2);
    step(3'b110, 1'b0, 1'b0, 1'b0); chk("pr_c2_grant", 32'(pr_grant), 32'h2);
    step(3'b110, 1'b1, 1'b0, 1'b0); chk("pr_c3_grant", 32'(pr_grant), 32'h2);
    step(3'b110, 1'b0, 1'b0, 1'b0); chk("pr_c4_grant", 32'(pr_grant), 32'h2);
    chk("pr_c4_qexp", 32'(pr_qexp), 32'h1);
    step(3'b110, 1'b0, 1'b0, 1'b0); chk("pr_c5_grant", 32'(pr_grant), 32'h2);
    step(3'b111, 1'b0, 1'b0, 1'b0); chk("pr_c6_grant", 32'(pr_grant), 32'h2);
    step(3'b111, 1'b0, 1'b0, 1'b0); chk("pr_c7_grant", 32'(pr_grant), 32'h1);
    chk("pr_c7_enc", 32'(pr_enc), 32'h0);

    // Owner drops acc in the same cycle as ack: grant holds one more cycle
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b010, 1'b1, 1'b0, 1'b0);
    chk("ackdrop_grant0", 32'(rr_grant), 32'h1);
    chk("ackdrop_p_ack", 32'(rr_p_ack), 32'h1);
    step(3'b010, 1'b0, 1'b0, 1'b0); chk("ackdrop_grant1", 32'(rr_grant), 32'h1);
    step(3'b010, 1'b0, 1'b0, 1'b0); chk("ackdrop_grant2", 32'(rr_grant), 32'h2);

    // Read data routed only to owner 1
    vld_seen = 0;
    for (int c = 0; c < 8; c++) begin
      step(3'b010, 1'b0, 1'b1, 1'b0);
      p_dat[DW +: DW] = 16'hB000 | 16'(c);
      #1;
      chk("read_p_vld", 32'(rr_p_vld), 32'h2);
      chk("read_dat_o", 32'(if_rr.dat_o), 32'hB000 | 32'(c));
      if (rr_p_vld == 3'b010) vld_seen++;
    end
    step(3'b010, 1'b0, 1'b0, 1'b0);
    chk("read_p_vld_idle", 32'(rr_p_vld), 32'h0);
    chk("read_vld_count", 32'(vld_seen), 32'd8);

    // Reset with owner 2 and one ack counted
    step(3'b100, 1'b0, 1'b0, 1'b0); chk("rst_pre_grant1", 32'(rr_grant), 32'h2);
    step(3'b100, 1'b1, 1'b0, 1'b0); chk("rst_pre_grant2", 32'(rr_grant), 32'h4);
    step(3'b100, 1'b0, 1'b0, 1'b1); chk("rst_pre_grant3", 32'(rr_grant), 32'h4);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk("rst_grant", 32'(rr_grant), 32'h1);
    chk("rst_enc", 32'(rr_enc), 32'h0);
    chk("rst_qexp", 32'(rr_qexp), 32'h0);
    chk("rst_adr_o", if_rr.adr_o, 32'hA000_0000);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk("rst_count_cleared", 32'(rr_qexp), 32'h0);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk("rst_count_second", 32'(rr_qexp), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter_v2.md
Name: sdram_port_arbiter_v2

Overview:
- Parametrised N-port arbiter on the SDRAM-clock side between per-port wb_port instances and the SDRAM controller command/data interface.
- Successor to the fixed three-port, 16-bit round-robin arbiter, generalised in four ways:
  - configurable port count and data width;
  - selectable round-robin or fixed-priority policy;
  - per-grant quantum that bounds back-to-back commands from one port;
  - grant-status outputs.
- Single clock domain. Buffer-write snooping stays in the wb_clk domain and is out of scope.

Parameters:
- WB_PORTS, 3, number of ports (1..16)
- DW, 16, SDRAM data width (8, 16 or 32)
- AW, 32, address width
- POLICY, "RR", "RR" = round robin starting after current owner; "PRIO" = lowest index wins
- QUANTUM, 4, accepted commands (ack_i pulses) one owner may take while others request; 0 = unlimited
- PW, $clog2(WB_PORTS) (min 1), port index width (derived; do not override)

Ports:
- sdram_clk  in  1  clock
- sdram_rst  in  1  synchronous active-high reset
- sdram_idle_i  in  1  controller idle, safe point for re-arbitration
- p_adr_i  in  WB_PORTS*AW  per-port command address
- p_we_i  in  WB_PORTS  per-port write flag
- p_acc_i  in  WB_PORTS  per-port command valid (request)
- p_dat_i  in  WB_PORTS*DW  per-port write data
- p_sel_i  in  WB_PORTS*DW/8  per-port byte select
- p_dv_i  in  WB_PORTS  per-port write-data valid
- p_ack_o  out  WB_PORTS  command accepted, routed to owner only
- p_vld_o  out  WB_PORTS  read data valid, routed to owner only
- adr_o  out  AW  owner address
- we_o  out  1  owner write flag
- acc_o  out  1  owner command valid
- dat_o  out  DW  owner write data
- sel_o  out  DW/8  owner byte select
- dv_o  out  1  owner write-data valid
- ack_i  in  1  controller accepted command
- vld_i  in  1  controller read data valid
- grant_o  out  WB_PORTS  one-hot owner (registered)
- grant_enc_o  out  PW  binary owner index (registered)
- quantum_exp_o  out  1  owner has used its quantum (registered)

Behaviour:
- Reset values: grant_o = 1 (port 0), grant_enc_o = 0, quantum counter = 0, quantum_exp_o = 0.
- All downstream outputs are a combinational mux of the per-port inputs, indexed by registered grant_enc_o.
- p_ack_o = {WB_PORTS{ack_i}} & grant_o; p_vld_o = {WB_PORTS{vld_i}} & grant_o.
- Non-owners never see ack or vld.
- Switch condition `sw`, evaluated each cycle: sdram_idle_i & !ack_i & (!p_acc_i[owner] | (quantum_exp_o & other_req)), where other_req = |(p_acc_i & ~grant_o).
- When sw = 1, the new owner is registered on the next edge:
  - "RR": first requester scanning owner+1 upward with wrap from WB_PORTS-1 to 0. The owner itself is considered last.
  - "PRIO": lowest-index requester.
  - No requester: owner unchanged.
- Re-arbitration latency: 1 cycle. New-owner outputs are valid in the cycle after sw.
- Grant never changes in a cycle with ack_i = 1. This guarantees the ack reaches the port whose command was accepted.
- Quantum counter (width $clog2(QUANTUM+1)):
  - increments on ack_i while not saturated at QUANTUM;
  - clears to 0 on any owner change;
  - quantum_exp_o = (count == QUANTUM) & (QUANTUM != 0).
- Forced switch on quantum expiry: the old owner keeps p_acc_i high. Its command is retried when it is granted again. No command is lost, because switching only occurs with ack_i = 0.
- Quantum expired but no other requester: owner keeps the grant and the counter stays saturated.
- WB_PORTS = 1: grant is fixed at port 0; the counter still runs.
- sdram_rst mid-burst: all state returns to reset values on the next edge. Outputs follow port 0 immediately after.
- X-safety: grant_enc_o is always < WB_PORTS.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - POLICY encodings as localparams;
  - a clog2 helper;
  - functions rr_next(current_onehot, req) and prio_next(req) returning one-hot;
  - function onehot2bin.
- One sub-module is natural: sdram_arb_grant, containing the grant/quantum state register and the policy select. The top-level contains only the data muxes and ack/vld routing.

Test Plan:
- Reset, no requests, idle = 1 -> grant_o = 001, enc = 0, acc_o = 0 for 10 cycles.
- RR, WB_PORTS = 3, all p_acc_i = 1, QUANTUM = 2, ack_i pulsed every 3rd cycle, idle = 1 -> grant sequence 0,1,2,0, two acks per owner, quantum_exp_o high before each switch.
- PRIO, p_acc_i = 110 held, port 0 raises acc mid-stream -> next safe point grants port 0. Port 2 is never granted while ports 0 or 1 request.
- sdram_idle_i = 1, ack_i = 1, owner acc drops in the same cycle -> grant does not change that cycle; it changes the following cycle. The ack appears only on the old owner's p_ack_o.
- Read: owner 1 granted, vld_i pulsed 8 times with dat_i pattern -> p_vld_o = 010 exactly 8 cycles, other bits 0.
- sdram_rst asserted while grant = port 2 with count = 1 -> next cycle grant_o = 001, count = 0, quantum_exp_o = 0.
